// File: rtl/dctq_block_arbiter.sv
// Round-robin arbiter sharing one DCTQ engine among NREQ pixel-block sources.
// Each issued 8x8 block is tagged so the coefficient stream can be attributed to its owner.
module dctq_block_arbiter #(
  parameter int NREQ      = 4,
  parameter int PIX_W     = 8,
  parameter int TAG_DEPTH = 4,
  parameter int TAG_W     = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*PIX_W-1:0]   req_pix,
  input  logic [NREQ-1:0]         req_pix_valid,
  output logic [NREQ-1:0]         req_pix_ack,
  output logic [NREQ-1:0]         grant,
  output logic                    eng_start,
  output logic                    eng_hold,
  output logic [PIX_W-1:0]        eng_pix,
  input  logic                    eng_ready,
  input  logic                    eng_valid,
  input  logic                    out_ready,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    out_tag_valid,
  output logic                    out_last,
  output logic                    busy,
  output logic                    err_orphan
);

  localparam int PTR_W = $clog2(TAG_DEPTH);

  typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

  state_t            state, state_next;
  logic [NREQ-1:0]   grant_next;
  logic [TAG_W-1:0]  rr_ptr, rr_ptr_next, win_id;
  logic [5:0]        pix_cnt, coef_cnt;
  logic              grant_ok, push, pop, last_ack;
  logic              fifo_empty, fifo_full, gnt_pix_valid;

  logic [TAG_W-1:0]  tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PTR_W+1)'(TAG_DEPTH));
  assign grant_ok   = (|req_valid) && eng_ready && !fifo_full && out_ready;

  // Winner is the requester at the smallest rotational distance from rr_ptr.
  always_comb begin
    int best_d;
    int d;
    win_id = '0;
    best_d = NREQ;
    d      = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i]) begin
        d = (i - int'(rr_ptr) + NREQ) % NREQ;
        if (d < best_d) begin
          best_d = d;
          win_id = TAG_W'(i);
        end
      end
    end
  end

  always_comb begin
    eng_pix = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) eng_pix = req_pix[i*PIX_W +: PIX_W];
    end
  end

  assign gnt_pix_valid = |(grant & req_pix_valid);
  assign eng_start     = (state == LOAD);
  assign eng_hold      = !out_ready || ((state == LOAD) && !gnt_pix_valid);
  assign req_pix_ack   = eng_hold ? '0 : (grant & req_pix_valid);
  assign last_ack      = (|req_pix_ack) && (pix_cnt == 6'd63);

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_next  = state;
    grant_next  = grant;
    rr_ptr_next = rr_ptr;
    push        = 1'b0;
    case (state)
      IDLE: begin
        if (grant_ok) begin
          state_next  = LOAD;
          grant_next  = NREQ'(1) << win_id;
          rr_ptr_next = TAG_W'((int'(win_id) + 1) % NREQ);
          push        = 1'b1;
        end
      end
      LOAD: begin
        if (last_ack) begin
          if (grant_ok) begin
            grant_next  = NREQ'(1) << win_id;
            rr_ptr_next = TAG_W'((int'(win_id) + 1) % NREQ);
            push        = 1'b1;
          end else begin
            grant_next = '0;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      grant   <= '0;
      rr_ptr  <= '0;
      pix_cnt <= '0;
    end else begin
      state  <= state_next;
      grant  <= grant_next;
      rr_ptr <= rr_ptr_next;
      if (|req_pix_ack) pix_cnt <= pix_cnt + 6'd1;
    end
  end

  assign out_tag_valid = eng_valid && !fifo_empty;
  assign out_last      = out_tag_valid && (coef_cnt == 6'd63);
  assign pop           = out_last;
  assign out_tag       = fifo_empty ? '0 : tag_mem[rd_ptr];
  assign busy          = (state == LOAD) || !fifo_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      coef_cnt   <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (out_tag_valid) coef_cnt <= coef_cnt + 6'd1;
      if (eng_valid && fifo_empty) err_orphan <= 1'b1;
    end
  end

  // NOTE: tag storage is not reset; out_tag is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= win_id;
  end

endmodule

// File: tb/tb_dctq_block_arbiter.sv
// Directed bench for dctq_block_arbiter: single block, round-robin, stalls,
// backpressure, tag FIFO full and orphan/async-reset behaviour.
module tb_dctq_block_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid, req_pix_valid, req_pix_ack, grant;
  logic [31:0] req_pix;
  logic        eng_start, eng_hold, eng_ready, eng_valid, out_ready;
  logic [7:0]  eng_pix;
  logic [1:0]  out_tag;
  logic        out_tag_valid, out_last, busy, err_orphan;

  int n_cmp = 0;
  int n_bad = 0;

  logic [5:0] pix_idx [4];

  always #5 clk = ~clk;

  dctq_block_arbiter #(.NREQ(4), .PIX_W(8), .TAG_DEPTH(4), .TAG_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_pix(req_pix),
    .req_pix_valid(req_pix_valid), .req_pix_ack(req_pix_ack), .grant(grant),
    .eng_start(eng_start), .eng_hold(eng_hold), .eng_pix(eng_pix),
    .eng_ready(eng_ready), .eng_valid(eng_valid), .out_ready(out_ready),
    .out_tag(out_tag), .out_tag_valid(out_tag_valid), .out_last(out_last),
    .busy(busy), .err_orphan(err_orphan)
  );

  // Requester i presents pixel value i*64 + (pixels of i consumed so far, mod 64).
  always_comb begin
    for (int i = 0; i < 4; i++) req_pix[i*8 +: 8] = 8'(i*64) + {2'b00, pix_idx[i]};
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) pix_idx[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) if (req_pix_ack[i]) pix_idx[i] <= pix_idx[i] + 6'd1;
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req_valid = 4'b0; req_pix_valid = 4'hF;
    eng_valid = 1'b0; eng_ready = 1'b1; out_ready = 1'b1;
    adv(); adv();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 4'b0; req_pix_valid = 4'hF;
    eng_valid = 1'b0; eng_ready = 1'b1; out_ready = 1'b1;
    #2;
    n_cmp++; if (grant !== 4'b0) begin n_bad++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    n_cmp++; if (eng_start !== 1'b0) begin n_bad++; $display("FAIL reset_eng_start got=%b exp=0", eng_start); end
    n_cmp++; if (eng_hold !== 1'b0) begin n_bad++; $display("FAIL reset_eng_hold got=%b exp=0", eng_hold); end
    n_cmp++; if (eng_pix !== 8'd0) begin n_bad++; $display("FAIL reset_eng_pix got=%0d exp=0", eng_pix); end
    n_cmp++; if (req_pix_ack !== 4'b0) begin n_bad++; $display("FAIL reset_ack got=%b exp=0000", req_pix_ack); end
    n_cmp++; if ({out_tag, out_tag_valid, out_last} !== 4'b0) begin n_bad++; $display("FAIL reset_out got=%b exp=0000", {out_tag, out_tag_valid, out_last}); end
    n_cmp++; if ({busy, err_orphan} !== 2'b0) begin n_bad++; $display("FAIL reset_busy_err got=%b exp=00", {busy, err_orphan}); end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0001; req_pix_valid = 4'b0001;
    #1;
    n_cmp++; if (grant !== 4'b0) begin n_bad++; $display("FAIL single_pre_grant got=%b exp=0000", grant); end
    adv();
    req_valid = 4'b0;
    #1;
    n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL single_grant got=%b exp=0001", grant); end
    n_cmp++; if (eng_start !== 1'b1) begin n_bad++; $display("FAIL single_start got=%b exp=1", eng_start); end
    for (int m = 0; m < 64; m++) begin
      n_cmp++; if (req_pix_ack !== 4'b0001) begin n_bad++; $display("FAIL single_ack m=%0d got=%b exp=0001", m, req_pix_ack); end
      n_cmp++; if (eng_pix !== 8'(m)) begin n_bad++; $display("FAIL single_pix m=%0d got=%0d exp=%0d", m, eng_pix, m); end
      adv();
    end
    n_cmp++; if (grant !== 4'b0) begin n_bad++; $display("FAIL single_end_grant got=%b exp=0000", grant); end
    n_cmp++; if (eng_start !== 1'b0) begin n_bad++; $display("FAIL single_end_start got=%b exp=0", eng_start); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got=%b exp=1", busy); end
    eng_valid = 1'b1;
    #1;
    for (int k = 0; k < 64; k++) begin
      n_cmp++; if ({out_tag_valid, out_tag} !== 3'b100) begin n_bad++; $display("FAIL single_tag k=%0d got=%b exp=100", k, {out_tag_valid, out_tag}); end
      n_cmp++; if (out_last !== (k == 63)) begin n_bad++; $display("FAIL single_last k=%0d got=%b exp=%b", k, out_last, (k == 63)); end
      adv();
    end
    eng_valid = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_drained_busy got=%b exp=0", busy); end
    n_cmp++; if (err_orphan !== 1'b0) begin n_bad++; $display("FAIL single_orphan got=%b exp=0", err_orphan); end
  endtask

  task automatic test_round_robin();
    int order [5];
    order = '{0, 1, 2, 3, 0};
    do_reset();
    req_valid = 4'b1111;
    #1;
    adv();
    eng_valid = 1'b1;
    for (int m = 0; m < 320; m++) begin
      if (m == 256) req_valid = 4'b0;
      #1;
      n_cmp++; if (grant !== 4'(1 << order[m/64])) begin n_bad++; $display("FAIL rr_grant m=%0d got=%b exp=%b", m, grant, 4'(1 << order[m/64])); end
      n_cmp++; if (req_pix_ack !== 4'(1 << order[m/64])) begin n_bad++; $display("FAIL rr_ack m=%0d got=%b exp=%b", m, req_pix_ack, 4'(1 << order[m/64])); end
      n_cmp++; if (eng_pix !== 8'(order[m/64]*64 + m%64)) begin n_bad++; $display("FAIL rr_pix m=%0d got=%0d exp=%0d", m, eng_pix, order[m/64]*64 + m%64); end
      n_cmp++; if (out_tag !== 2'(order[m/64])) begin n_bad++; $display("FAIL rr_tag m=%0d got=%0d exp=%0d", m, out_tag, order[m/64]); end
      n_cmp++; if (out_last !== (m%64 == 63)) begin n_bad++; $display("FAIL rr_last m=%0d got=%b exp=%b", m, out_last, (m%64 == 63)); end
      adv();
    end
    eng_valid = 1'b0;
    #1;
    n_cmp++; if (grant !== 4'b0) begin n_bad++; $display("FAIL rr_end_grant got=%b exp=0000", grant); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rr_end_busy got=%b exp=0", busy); end
    n_cmp++; if (err_orphan !== 1'b0) begin n_bad++; $display("FAIL rr_orphan got=%b exp=0", err_orphan); end
  endtask

  task automatic test_stall();
    int p, cyc, stall_left;
    do_reset();
    req_valid = 4'b0001; req_pix_valid = 4'b0001;
    #1;
    adv();
    req_valid = 4'b0;
    p = 0; cyc = 0; stall_left = 5;
    while (p < 64 && cyc < 100) begin
      if (p == 20 && stall_left > 0) begin
        req_pix_valid = 4'b0000;
        #1;
        n_cmp++; if ({eng_hold, req_pix_ack} !== 5'b10000) begin n_bad++; $display("FAIL stall_hold cyc=%0d got=%b exp=10000", cyc, {eng_hold, req_pix_ack}); end
        stall_left--;
      end else begin
        req_pix_valid = 4'b0001;
        #1;
        n_cmp++; if (req_pix_ack !== 4'b0001) begin n_bad++; $display("FAIL stall_ack cyc=%0d got=%b exp=0001", cyc, req_pix_ack); end
        n_cmp++; if (eng_pix !== 8'(p)) begin n_bad++; $display("FAIL stall_pix p=%0d got=%0d exp=%0d", p, eng_pix, p); end
        p++;
      end
      cyc++;
      adv();
    end
    n_cmp++; if (cyc !== 69) begin n_bad++; $display("FAIL stall_cycles got=%0d exp=69", cyc); end
    n_cmp++; if (grant !== 4'b0) begin n_bad++; $display("FAIL stall_end_grant got=%b exp=0000", grant); end
  endtask

  task automatic test_backpressure();
    int p, cyc, bp_left;
    do_reset();
    req_valid = 4'b0001; out_ready = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (eng_hold !== 1'b1) begin n_bad++; $display("FAIL bp_idle_hold c=%0d got=%b exp=1", c, eng_hold); end
      adv();
      n_cmp++; if (grant !== 4'b0) begin n_bad++; $display("FAIL bp_no_grant c=%0d got=%b exp=0000", c, grant); end
    end
    out_ready = 1'b1;
    #1;
    adv();
    n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL bp_grant got=%b exp=0001", grant); end
    req_valid = 4'b0;
    p = 0; cyc = 0; bp_left = 3;
    while (p < 64 && cyc < 100) begin
      if (p == 10 && bp_left > 0) begin
        out_ready = 1'b0;
        #1;
        n_cmp++; if ({eng_hold, req_pix_ack} !== 5'b10000) begin n_bad++; $display("FAIL bp_hold cyc=%0d got=%b exp=10000", cyc, {eng_hold, req_pix_ack}); end
        bp_left--;
      end else begin
        out_ready = 1'b1;
        #1;
        n_cmp++; if (eng_pix !== 8'(p) || req_pix_ack !== 4'b0001) begin n_bad++; $display("FAIL bp_stream p=%0d got pix=%0d ack=%b exp pix=%0d ack=0001", p, eng_pix, req_pix_ack, p); end
        p++;
      end
      cyc++;
      adv();
    end
    n_cmp++; if (cyc !== 67) begin n_bad++; $display("FAIL bp_cycles got=%0d exp=67", cyc); end
  endtask

  task automatic test_fifo_full();
    do_reset();
    req_valid = 4'b1111;
    #1;
    adv();
    for (int m = 0; m < 256; m++) begin
      if (m % 64 == 0) begin
        n_cmp++; if (grant !== 4'(1 << (m/64))) begin n_bad++; $display("FAIL full_grant m=%0d got=%b exp=%b", m, grant, 4'(1 << (m/64))); end
      end
      adv();
    end
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if ({grant, eng_start, busy} !== 6'b000001) begin n_bad++; $display("FAIL full_idle c=%0d got=%b exp=000001", c, {grant, eng_start, busy}); end
      adv();
    end
    eng_valid = 1'b1;
    #1;
    for (int k = 0; k < 64; k++) begin
      n_cmp++; if (out_tag !== 2'd0 || out_last !== (k == 63)) begin n_bad++; $display("FAIL full_drain k=%0d got tag=%0d last=%b exp tag=0 last=%b", k, out_tag, out_last, (k == 63)); end
      adv();
    end
    eng_valid = 1'b0;
    #1;
    n_cmp++; if (out_tag !== 2'd1) begin n_bad++; $display("FAIL full_next_tag got=%0d exp=1", out_tag); end
    adv();
    n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL full_fifth_grant got=%b exp=0001", grant); end
    n_cmp++; if (err_orphan !== 1'b0) begin n_bad++; $display("FAIL full_orphan got=%b exp=0", err_orphan); end
  endtask

  task automatic test_error_reset();
    do_reset();
    eng_valid = 1'b1;
    #1;
    adv();
    eng_valid = 1'b0;
    #1;
    n_cmp++; if (err_orphan !== 1'b1) begin n_bad++; $display("FAIL orphan_set got=%b exp=1", err_orphan); end
    n_cmp++; if (out_tag_valid !== 1'b0) begin n_bad++; $display("FAIL orphan_tag_valid got=%b exp=0", out_tag_valid); end
    adv(); adv();
    n_cmp++; if (err_orphan !== 1'b1) begin n_bad++; $display("FAIL orphan_sticky got=%b exp=1", err_orphan); end
    req_valid = 4'b0001;
    #1;
    adv();
    req_valid = 4'b0;
    for (int p = 0; p < 30; p++) adv();
    n_cmp++; if (eng_pix !== 8'd30) begin n_bad++; $display("FAIL mid_pix got=%0d exp=30", eng_pix); end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({grant, eng_start, eng_pix, req_pix_ack} !== 17'b0) begin n_bad++; $display("FAIL async_rst_in got=%b exp=0", {grant, eng_start, eng_pix, req_pix_ack}); end
    n_cmp++; if ({out_tag, out_tag_valid, out_last, busy, err_orphan} !== 6'b0) begin n_bad++; $display("FAIL async_rst_out got=%b exp=000000", {out_tag, out_tag_valid, out_last, busy, err_orphan}); end
    adv();
    reset_n = 1'b1; req_valid = 4'b1111;
    #1;
    adv();
    n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL rr_ptr_after_reset got=%b exp=0001", grant); end
  endtask

  initial begin
    reset_n = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_backpressure();
    test_fifo_full();
    test_error_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
